// File: rtl/puzzle_move_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// puzzle_move_ctrl_pkg
//   Shared types, constants and helpers for the 8-puzzle move sequencer.
//   Contents:
//     TILE_W, N_TILES, SOLVED_BOARD   board geometry and the goal layout
//     dir_t                           direction the blank tile moves in
//     state_t                         sequencer FSM states
//     legal(pos, dir)                 does the move stay on the 3x3 board
//     target(pos, dir)                blank position after the move
//     bcd_inc(v)                      4-digit BCD +1, saturating at 9999
// ---------------------------------------------------------------------------
package puzzle_move_ctrl_pkg;

   localparam int TILE_W  = 4;
   localparam int N_TILES = 9;

   // Tile i sits at [4i+3:4i]; tiles 0..7 hold 1..8, tile 8 is the blank.
   localparam logic [35:0] SOLVED_BOARD = 36'h0_8765_4321;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
   typedef enum logic [1:0] {IDLE, SHUFFLE, CLEAR} state_t;

   // Column of a board index, written out to avoid a modulo operator.
   function automatic logic [1:0] col_of(input logic [3:0] pos);
      case (pos)
         4'd0, 4'd3, 4'd6: col_of = 2'd0;
         4'd1, 4'd4, 4'd7: col_of = 2'd1;
         default:          col_of = 2'd2;
      endcase
   endfunction

   function automatic logic legal(input logic [3:0] pos, input dir_t dir);
      case (dir)
         DIR_UP:    legal = (pos >= 4'd3);
         DIR_DOWN:  legal = (pos <= 4'd5);
         DIR_LEFT:  legal = (col_of(pos) != 2'd0);
         default:   legal = (col_of(pos) != 2'd2);
      endcase
   endfunction

   function automatic logic [3:0] target(input logic [3:0] pos, input dir_t dir);
      case (dir)
         DIR_UP:    target = pos - 4'd3;
         DIR_DOWN:  target = pos + 4'd3;
         DIR_LEFT:  target = pos - 4'd1;
         default:   target = pos + 4'd1;
      endcase
   endfunction

   // Ripple the carry digit by digit; 9999 is a hard ceiling.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int d = 0; d < 4; d++) begin
            if (carry) begin
               if (r[d*4 +: 4] == 4'd9) begin
                  r[d*4 +: 4] = 4'd0;
               end else begin
                  r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/puzzle_move_ctrl_if.sv
// ---------------------------------------------------------------------------
// puzzle_move_ctrl_if
//   Bundle between the button/board side of the system and the move sequencer.
//     btn        raw buttons [0]up [1]down [2]left [3]right [4]scramble
//     board      9 tiles x 4 bits, tile i at [4i+3:4i], 0 = blank
//     blank_pos  index 0..8 of the blank tile
//     move_cnt   4-digit BCD count of legal player moves
//     solved     board equals the goal layout
//     busy       scramble in progress
//   master: drives btn, observes the rest.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface puzzle_move_ctrl_if;

   logic [4:0]  btn;
   logic [35:0] board;
   logic [3:0]  blank_pos;
   logic [15:0] move_cnt;
   logic        solved;
   logic        busy;

   modport master (
      output btn,
      input  board, blank_pos, move_cnt, solved, busy
   );

   modport slave (
      input  btn,
      output board, blank_pos, move_cnt, solved, busy
   );

endinterface

// File: rtl/puzzle_move_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// puzzle_move_ctrl_btn_debounce
//   One push button: 2-FF synchroniser, stability counter, rising-edge pulse.
//   The debounced level only changes after the synchronised input has
//   differed from it for DEBOUNCE_CYCLES consecutive cycles; pulse is high
//   for the single cycle after the debounced level rises.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     btn          raw (asynchronous) button level
//     pulse        one-cycle command strobe on an accepted press
// ---------------------------------------------------------------------------
module puzzle_move_ctrl_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_reg;
   logic          level_reg;
   logic          pulse_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg  <= '0;
         level_reg <= 1'b0;
         pulse_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync_reg  <= {sync_reg[0], btn};
         pulse_reg <= 1'b0;
         // Any cycle that agrees with the current level restarts the count,
         // so only an unbroken run of the new level is accepted.
         if (sync_reg[1] == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_MAX) begin
            level_reg <= sync_reg[1];
            pulse_reg <= sync_reg[1];
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign pulse = pulse_reg;

endmodule

// File: rtl/puzzle_move_ctrl.sv
// ---------------------------------------------------------------------------
// puzzle_move_ctrl
//   Move sequencer for the 8-puzzle: debounced button presses become blank
//   tile moves, legal moves swap tiles and bump a BCD move counter, the
//   centre button runs an LFSR-driven scramble of SHUFFLE_MOVES attempts.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          puzzle_move_ctrl_if.slave (btn in; board, blank_pos,
//                  move_cnt, solved, busy out)
// ---------------------------------------------------------------------------
module puzzle_move_ctrl
   import puzzle_move_ctrl_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter int          SHUFFLE_MOVES   = 32,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   puzzle_move_ctrl_if.slave  bus
);

   logic [4:0] cmd;

   for (genvar gi = 0; gi < 5; gi++) begin : g_deb
      puzzle_move_ctrl_btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (bus.btn[gi]),
         .pulse (cmd[gi])
      );
   end

   state_t      state_reg, state_next;
   logic [3:0]  tile_reg  [N_TILES];
   logic [3:0]  tile_next [N_TILES];
   logic [3:0]  blank_reg, blank_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [7:0]  shuf_reg, shuf_next;
   logic [15:0] lfsr_reg;
   logic        solved_reg;
   logic        busy_reg;
   logic [35:0] board_flat;

   logic        move_req;
   dir_t        move_dir;
   logic [3:0]  tgt;

   for (genvar gi = 0; gi < N_TILES; gi++) begin : g_flat
      assign board_flat[gi*TILE_W +: TILE_W] = tile_reg[gi];
   end

   always_comb begin
      state_next = state_reg;
      tile_next  = tile_reg;
      blank_next = blank_reg;
      cnt_next   = cnt_reg;
      shuf_next  = shuf_reg;
      move_req   = 1'b0;
      move_dir   = DIR_UP;
      tgt        = blank_reg;

      case (state_reg)
         IDLE: begin
            // Fixed priority; lower-priority strobes in the same cycle are lost.
            if (cmd[4]) begin
               state_next = SHUFFLE;
               shuf_next  = '0;
            end else if (cmd[0]) begin
               move_req = 1'b1;
               move_dir = DIR_UP;
            end else if (cmd[1]) begin
               move_req = 1'b1;
               move_dir = DIR_DOWN;
            end else if (cmd[2]) begin
               move_req = 1'b1;
               move_dir = DIR_LEFT;
            end else if (cmd[3]) begin
               move_req = 1'b1;
               move_dir = DIR_RIGHT;
            end
         end
         SHUFFLE: begin
            // Button strobes are simply not looked at here, so nothing queues.
            move_req  = 1'b1;
            move_dir  = dir_t'(lfsr_reg[1:0]);
            shuf_next = shuf_reg + 8'd1;
            if (shuf_reg == 8'(SHUFFLE_MOVES - 1)) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (move_req && legal(blank_reg, move_dir)) begin
         tgt                  = target(blank_reg, move_dir);
         tile_next[blank_reg] = tile_reg[tgt];
         tile_next[tgt]       = '0;
         blank_next           = tgt;
         if (state_reg == IDLE) begin
            cnt_next = bcd_inc(cnt_reg);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         for (int i = 0; i < N_TILES; i++) begin
            tile_reg[i] <= SOLVED_BOARD[i*TILE_W +: TILE_W];
         end
         blank_reg  <= 4'd8;
         cnt_reg    <= '0;
         shuf_reg   <= '0;
         lfsr_reg   <= LFSR_SEED;
         solved_reg <= 1'b1;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         tile_reg   <= tile_next;
         blank_reg  <= blank_next;
         cnt_reg    <= cnt_next;
         shuf_reg   <= shuf_next;
         // Free-running in every state so the scramble depends on press timing.
         lfsr_reg   <= {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
         // Compares the current board, so it trails a board update by one cycle.
         solved_reg <= (board_flat == SOLVED_BOARD);
         busy_reg   <= (state_next != IDLE);
      end
   end

   assign bus.board     = board_flat;
   assign bus.blank_pos = blank_reg;
   assign bus.move_cnt  = cnt_reg;
   assign bus.solved    = solved_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puzzle_move_ctrl
//   Directed bench for puzzle_move_ctrl. A second instance with a one-cycle
//   debounce is used for the long move-counter run to keep it short.
// ---------------------------------------------------------------------------
module tb_puzzle_move_ctrl;

   localparam logic [35:0] SOLVED = 36'h0_8765_4321;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   puzzle_move_ctrl_if bus ();
   puzzle_move_ctrl_if fbus ();

   puzzle_move_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .SHUFFLE_MOVES   (32),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   puzzle_move_ctrl #(
      .DEBOUNCE_CYCLES (1),
      .SHUFFLE_MOVES   (32),
      .LFSR_SEED       (16'hACE1)
   ) dut_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (fbus)
   );

   int compared   = 0;
   int mismatched = 0;
   int presses    = 0;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] tile_of(input logic [35:0] b, input int i);
      return b[i*4 +: 4];
   endfunction

   function automatic logic [15:0] exp_bcd(input int n);
      int e;
      e = (n > 9999) ? 9999 : n;
      return {4'(e / 1000), 4'((e / 100) % 10), 4'((e / 10) % 10), 4'(e % 10)};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic press(input int b, input int hold);
      bus.btn[b] = 1'b1;
      repeat (hold) @(negedge clk);
      bus.btn[b] = 1'b0;
      repeat (15) @(negedge clk);
   endtask

   // Alternating left/right on the fast instance, two cycles per press.
   task automatic fast_to(input int n);
      while (presses < n) begin
         fbus.btn = (presses % 2 == 0) ? 5'b00100 : 5'b01000;
         repeat (2) @(negedge clk);
         presses++;
      end
      fbus.btn = 5'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      logic        found;
      int          busy_cnt;
      logic [8:0]  seen;
      logic [35:0] snap;
      int          cps [6];

      bus.btn  = 5'b0;
      fbus.btn = 5'b0;
      do_reset();

      // Reset state
      check("rst_board",  bus.board, SOLVED);
      check("rst_blank",  36'(bus.blank_pos), 36'd8);
      check("rst_cnt",    36'(bus.move_cnt), 36'h0);
      check("rst_solved", 36'(bus.solved), 36'd1);
      check("rst_busy",   36'(bus.busy), 36'd0);

      // Left: blank 8->7, solved drops one cycle after the board changes
      bus.btn[2] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.blank_pos != 4'd8) found = 1'b1;
      end
      check("left_seen", 36'(found), 36'd1);
      check("left_solved_same_cycle", 36'(bus.solved), 36'd1);
      @(negedge clk);
      check("left_solved_next", 36'(bus.solved), 36'd0);
      repeat (2) @(negedge clk);
      bus.btn[2] = 1'b0;
      repeat (15) @(negedge clk);
      check("left_blank", 36'(bus.blank_pos), 36'd7);
      check("left_tile7", 36'(tile_of(bus.board, 7)), 36'd0);
      check("left_tile8", 36'(tile_of(bus.board, 8)), 36'd8);
      check("left_cnt",   36'(bus.move_cnt), 36'h0001);

      // Right: back to solved
      press(3, 10);
      check("right_board",  bus.board, SOLVED);
      check("right_blank",  36'(bus.blank_pos), 36'd8);
      check("right_cnt",    36'(bus.move_cnt), 36'h0002);
      check("right_solved", 36'(bus.solved), 36'd1);

      // Illegal down and right from the corner
      do_reset();
      press(1, 10);
      press(3, 10);
      check("illegal_board",  bus.board, SOLVED);
      check("illegal_blank",  36'(bus.blank_pos), 36'd8);
      check("illegal_cnt",    36'(bus.move_cnt), 36'h0);
      check("illegal_solved", 36'(bus.solved), 36'd1);

      // Bouncing up button never accepted, steady press gives one move
      do_reset();
      for (int i = 0; i < 20; i++) begin
         bus.btn[0] = ~bus.btn[0];
         repeat (2) @(negedge clk);
      end
      bus.btn[0] = 1'b0;
      repeat (15) @(negedge clk);
      check("bounce_blank", 36'(bus.blank_pos), 36'd8);
      check("bounce_cnt",   36'(bus.move_cnt), 36'h0);
      press(0, 100);
      check("steady_blank", 36'(bus.blank_pos), 36'd5);
      check("steady_cnt",   36'(bus.move_cnt), 36'h0001);
      check("steady_tile5", 36'(tile_of(bus.board, 5)), 36'd0);
      check("steady_tile8", 36'(tile_of(bus.board, 8)), 36'd6);

      // Left + up together: up wins
      do_reset();
      bus.btn = 5'b00101;
      repeat (10) @(negedge clk);
      bus.btn = 5'b0;
      repeat (15) @(negedge clk);
      check("prio_blank", 36'(bus.blank_pos), 36'd5);
      check("prio_cnt",   36'(bus.move_cnt), 36'h0001);
      check("prio_tile7", 36'(tile_of(bus.board, 7)), 36'd8);

      // Scramble with move presses during busy
      do_reset();
      press(2, 10);
      check("pre_shuf_cnt", 36'(bus.move_cnt), 36'h0001);
      bus.btn[4] = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (i == 8)  bus.btn[4] = 1'b0;
         if (i == 12) bus.btn[0] = 1'b1;
         if (i == 14) bus.btn[3] = 1'b1;
         if (i == 24) bus.btn[0] = 1'b0;
         if (i == 26) bus.btn[3] = 1'b0;
         if (bus.busy) busy_cnt++;
      end
      check("shuf_busy_cycles", 36'(busy_cnt), 36'd33);
      check("shuf_cnt", 36'(bus.move_cnt), 36'h0);
      seen = '0;
      for (int i = 0; i < 9; i++) begin
         if (tile_of(bus.board, i) < 4'd9) seen[tile_of(bus.board, i)] = 1'b1;
      end
      check("shuf_perm", 36'(seen), 36'h1FF);
      check("shuf_blank_tile", 36'(tile_of(bus.board, int'(bus.blank_pos))), 36'd0);
      snap = bus.board;
      repeat (20) @(negedge clk);
      check("shuf_no_queue_board", bus.board, snap);
      check("shuf_no_queue_cnt",   36'(bus.move_cnt), 36'h0);

      // Reset in the middle of a scramble
      bus.btn[4] = 1'b1;
      repeat (8) @(negedge clk);
      bus.btn[4] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.busy) found = 1'b1;
         else @(negedge clk);
      end
      check("mid_busy_seen", 36'(found), 36'd1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_board", bus.board, SOLVED);
      check("mid_rst_busy",  36'(bus.busy), 36'd0);
      check("mid_rst_blank", 36'(bus.blank_pos), 36'd8);
      check("mid_rst_cnt",   36'(bus.move_cnt), 36'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Long left/right run on the fast instance: BCD carries and saturation
      cps = '{9, 10, 99, 100, 9999, 10005};
      for (int k = 0; k < 6; k++) begin
         fast_to(cps[k]);
         check($sformatf("cnt_after_%0d", cps[k]), 36'(fbus.move_cnt), 36'(exp_bcd(cps[k])));
         check($sformatf("blank_after_%0d", cps[k]), 36'(fbus.blank_pos),
               (cps[k] % 2 == 1) ? 36'd7 : 36'd8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
